// File: rtl/space_invaders_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : space_invaders_pkg
//  Description : Shared types and screen/bullet constants for the video path.
//  Revision    : 1.0 - initial release
// ============================================================================
package space_invaders_pkg;

    localparam int SCREEN_W                = 640;
    localparam int SCREEN_H                = 480;
    localparam int DEFAULT_BULLET_STEP     = 4;
    localparam int DEFAULT_BULLET_OFFSET_Y = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } bullet_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_sync
//  Description : Brings vsync into the Clk domain and emits a one-cycle tick
//                on each synchronized rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;
    logic r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_sync1     <= i_frame_clk;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_tick      <= r_sync2 & ~r_sync_prev;
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/bullet_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_controller
//  Description : Player bullet launch/flight/retire control, one step per
//                frame. Optional post-retire cooldown via BULLET_COOLDOWN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_controller
    import space_invaders_pkg::*;
#(
    parameter int BULLET_STEP     = DEFAULT_BULLET_STEP,
    parameter int BULLET_OFFSET_Y = DEFAULT_BULLET_OFFSET_Y,
    parameter int Y_MIN           = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic       hit,
    input  logic [9:0] playerX,
    input  logic [9:0] playerY,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       bullet_active,
    output logic       shot_fired
);

    localparam int          c_cd_w      = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [10:0] c_top_limit = 11'(Y_MIN + BULLET_STEP);
    localparam logic [9:0]  c_step      = 10'(BULLET_STEP);
    localparam logic [9:0]  c_offset    = 10'(BULLET_OFFSET_Y);

    logic          w_tick;
    bullet_state_t r_state;
    bullet_state_t w_state_next;
    logic          r_fire_pending;
    logic          w_pending_next;
    logic [9:0]    w_x_next;
    logic [9:0]    w_y_next;
    logic [9:0]    w_launch_y;
    logic          w_active_next;
    logic          w_shot_next;
    logic          w_retire;
    logic          w_cooldown_zero;

    frame_tick_sync u_frame_tick_sync (
        .clk         (Clk),
        .rst         (Reset),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

`ifdef BULLET_COOLDOWN_EN
    localparam logic [c_cd_w-1:0] c_cd_load = c_cd_w'(COOLDOWN_FRAMES);

    logic [c_cd_w-1:0] r_cooldown;
    logic [c_cd_w-1:0] w_cooldown_next;

    // Retire only happens while FLYING, when the counter is already zero.
    always_comb begin
        w_cooldown_next = r_cooldown;
        if (w_retire)
            w_cooldown_next = c_cd_load;
        else if (w_tick && (r_cooldown != '0))
            w_cooldown_next = r_cooldown - 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_cooldown <= '0;
        else
            r_cooldown <= w_cooldown_next;
    end

    assign w_cooldown_zero = (r_cooldown == '0);
`else
    logic [c_cd_w-1:0] w_cooldown;

    assign w_cooldown      = '0;
    assign w_cooldown_zero = (w_cooldown == '0);
`endif

    assign w_launch_y = (playerY < c_offset) ? 10'd0 : (playerY - c_offset);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_fire_pending;
        w_x_next       = bulletX;
        w_y_next       = bulletY;
        w_active_next  = bullet_active;
        w_shot_next    = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick && r_fire_pending && w_cooldown_zero) begin
                    w_state_next   = FLYING;
                    w_pending_next = 1'b0;
                    w_x_next       = playerX;
                    w_y_next       = w_launch_y;
                    w_active_next  = 1'b1;
                    w_shot_next    = 1'b1;
                end else if (fire) begin
                    w_pending_next = 1'b1;
                end
            end
            FLYING: begin
                // A hit on the same edge as a tick retires without moving.
                if (hit) begin
                    w_retire = 1'b1;
                end else if (w_tick) begin
                    if ({1'b0, bulletY} < c_top_limit)
                        w_retire = 1'b1;
                    else
                        w_y_next = bulletY - c_step;
                end
                if (w_retire) begin
                    w_state_next  = IDLE;
                    w_active_next = 1'b0;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_active_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_fire_pending <= 1'b0;
            bulletX        <= '0;
            bulletY        <= '0;
            bullet_active  <= 1'b0;
            shot_fired     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_fire_pending <= w_pending_next;
            bulletX        <= w_x_next;
            bulletY        <= w_y_next;
            bullet_active  <= w_active_next;
            shot_fired     <= w_shot_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bullet_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_controller
//  Description : Frame-level reference model bench for bullet_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bullet_controller;

`ifdef BULLET_COOLDOWN_EN
    localparam int C_COOL = 8;
`else
    localparam int C_COOL = 0;
`endif
    localparam int C_FIRST = C_COOL + 1;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       fire;
    logic       hit;
    logic [9:0] playerX;
    logic [9:0] playerY;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       bullet_active;
    logic       shot_fired;

    int total = 0;
    int bad   = 0;
    int shot_cnt = 0;

    // Frame-level reference model
    bit m_active;
    int m_x;
    int m_y;
    bit m_pending;
    int m_cool;
    int m_shots = 0;

    bullet_controller u_dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .fire          (fire),
        .hit           (hit),
        .playerX       (playerX),
        .playerY       (playerY),
        .bulletX       (bulletX),
        .bulletY       (bulletY),
        .bullet_active (bullet_active),
        .shot_fired    (shot_fired)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (shot_fired === 1'b1) shot_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_active"}, {31'd0, bullet_active}, {31'd0, m_active});
        check({tag, "_x"}, {22'd0, bulletX}, m_x);
        check({tag, "_y"}, {22'd0, bulletY}, m_y);
        check({tag, "_shots"}, shot_cnt, m_shots);
    endtask

    task automatic model_reset();
        m_active = 0; m_x = 0; m_y = 0; m_pending = 0; m_cool = 0;
    endtask

    task automatic model_frame();
        if (fire && !m_active) m_pending = 1;
        if (m_active) begin
            if (m_y < 4) begin
                m_active = 0;
                m_cool   = C_COOL;
            end else begin
                m_y -= 4;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_pending) begin
            m_x = playerX;
            m_y = (playerY < 8) ? 0 : playerY - 8;
            m_active  = 1;
            m_pending = 0;
            m_shots++;
        end
        if (fire && !m_active) m_pending = 1;
    endtask

    // Called at negedge+1; returns at negedge+1.
    task automatic frame();
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        #1;
        model_frame();
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        @(negedge Clk); #1;
        fire = 1'b0;
        if (!m_active) m_pending = 1;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(negedge Clk); #1;
        hit = 1'b0;
        if (m_active) begin
            m_active = 0;
            m_cool   = C_COOL;
        end
    endtask

    task automatic flush_cooldown();
        repeat (C_COOL + 1) frame();
    endtask

    initial begin
        int first_launch;
        Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; hit = 1'b0;
        playerX = '0; playerY = '0;
        model_reset();
        repeat (3) @(negedge Clk); #1;
        check_all("reset");
        check("reset_shot", {31'd0, shot_fired}, 0);
        Reset = 1'b0;
        @(negedge Clk); #1;

        for (int i = 0; i < 5; i++) begin
            frame();
            check_all("idle");
        end

        // Launch and flight
        playerX = 10'd320; playerY = 10'd440;
        pulse_fire();
        frame();
        check_all("launch");
        check("launch_x", {22'd0, bulletX}, 320);
        check("launch_y", {22'd0, bulletY}, 432);
        for (int k = 1; k <= 3; k++) begin
            frame();
            check_all("flight");
            check("flight_y", {22'd0, bulletY}, 432 - 4 * k);
        end
        playerX = 10'd100;
        fire = 1'b1;
        frame();
        fire = 1'b0;
        check_all("fire_held");
        check("fire_held_x", {22'd0, bulletX}, 320);

        pulse_hit();
        check_all("hit_idle_tick");
        flush_cooldown();

        // Off-top exit then held fire through cooldown
        playerY = 10'd11;
        pulse_fire();
        frame();
        check("top_launch_y", {22'd0, bulletY}, 3);
        fire = 1'b1;
        frame();
        check_all("top_exit");
        check("top_exit_y", {22'd0, bulletY}, 3);
        first_launch = 0;
        for (int k = 1; k <= C_FIRST; k++) begin
            frame();
            check_all("cooldown");
            if (first_launch == 0 && bullet_active === 1'b1) first_launch = k;
        end
        check("first_launch_frame", first_launch, C_FIRST);
        fire = 1'b0;
        pulse_hit();
        flush_cooldown();

        // Hit coinciding with tick
        playerY = 10'd208;
        pulse_fire();
        frame();
        check("hit_tick_pre_y", {22'd0, bulletY}, 200);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk); #1;
        hit = 1'b1;
        @(negedge Clk); #1;
        hit = 1'b0;
        m_active = 0; m_cool = C_COOL;
        check_all("hit_tick");
        check("hit_tick_y", {22'd0, bulletY}, 200);
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk); #1;
        check_all("hit_tick_after");
        flush_cooldown();

        // Saturated launch
        playerY = 10'd4;
        pulse_fire();
        frame();
        check_all("sat_launch");
        check("sat_y", {22'd0, bulletY}, 0);
        frame();
        check_all("sat_retire");
        flush_cooldown();

        // Short async reset mid-flight
        playerY = 10'd300;
        pulse_fire();
        frame();
        check_all("pre_reset");
        #1 Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 Reset = 1'b0;
        @(negedge Clk); #1;
        repeat (2) begin
            frame();
            check_all("post_reset");
        end

        // Randomized play
        for (int it = 0; it < 30; it++) begin
            playerX = 10'($urandom_range(0, 639));
            playerY = 10'($urandom_range(0, 479));
            if ($urandom_range(0, 1) == 1) pulse_fire();
            repeat ($urandom_range(1, 4)) begin
                frame();
                check_all("rand");
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_hit();
                check_all("rand_hit");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bullet_controller.md
# bullet_controller

Generates the player bullet's screen position for the Space Invaders video path. Accepts fire requests and collision hits, advances the bullet once per video frame, and drives `bulletX`/`bulletY`/`bullet_active` into the color mapper. It is the producer end of the bullet position interface that the color mapper consumes. The color mapper must gate all bullet drawing with `bullet_active`.

## Interface
- `BULLET_STEP`, 4: pixels moved upward per frame.
- `BULLET_OFFSET_Y`, 8: launch offset above `playerY`.
- `Y_MIN`, 0: top boundary row.
- `COOLDOWN_FRAMES`, 8: frames blocked after the bullet retires. Used only when `BULLET_COOLDOWN_EN` is defined.

Ports:
- `Clk`  in  1: system clock.
- `Reset`  in  1: asynchronous, active-high reset.
- `frame_clk`  in  1: vertical sync from the VGA controller. Asynchronous to `Clk`.
- `fire`  in  1: fire key level from the keycode decoder.
- `hit`  in  1: one-cycle collision pulse from the collision logic.
- `playerX`, `playerY`  in  10 each: player ship position.
- `bulletX`, `bulletY`  out  10 each: bullet position.
- `bullet_active`  out  1: bullet on screen.
- `shot_fired`  out  1: one-`Clk` pulse on launch (sound/score hook).

## Operation
- Reset values:
  - `bulletX`, `bulletY`, `bullet_active`, `shot_fired`: 0.
  - State: IDLE.
  - `fire_pending` and cooldown counter: 0.
- Frame tick:
  - `frame_clk` passes through a 2-flop synchronizer plus an edge register.
  - `tick` is high for exactly one `Clk` on each synchronized rising edge.
  - All motion happens only on `tick`.
- `fire_pending`:
  - Set in any cycle where `fire`=1 and state=IDLE.
  - Cleared on launch.
  - Never set while FLYING: one bullet at a time, no queued shots.
- States:
  - IDLE, on `tick` with `fire_pending`=1 and cooldown=0 → FLYING:
    - `bulletX` ← `playerX`.
    - `bulletY` ← `playerY` − `BULLET_OFFSET_Y`, saturating at 0.
    - `bullet_active` ← 1.
    - `shot_fired` = 1 for that one cycle.
  - FLYING, on `tick`:
    - If `bulletY` < `Y_MIN` + `BULLET_STEP` (compared in 11 bits): → IDLE (off top), `bullet_active` ← 0, cooldown loads.
    - Otherwise: `bulletY` ← `bulletY` − `BULLET_STEP`.
  - FLYING with `hit`=1 in any cycle → IDLE on that edge, `bullet_active` ← 0, cooldown loads.
- Boundary conditions:
  - `hit` and `tick` in the same cycle: `hit` wins; `bulletY` is not decremented.
  - `hit` while IDLE: ignored.
  - After retiring, `bulletX`/`bulletY` hold their last values.
  - `Reset` mid-flight clears everything immediately, with no `Clk` edge required.

## Timing
- From `frame_clk` rising, `tick` asserts on the 3rd `Clk` rising edge. Position outputs update at the edge that samples `tick`: latency 3–4 `Clk` cycles.
- `fire` is a level; one `Clk` of high while IDLE is sufficient. Launch occurs on the next `tick`.
- `hit` → `bullet_active`=0 after 1 `Clk` edge.
- All outputs are registered.

## Configuration
- Macro: `BULLET_COOLDOWN_EN`.
- Defined:
  - A `$clog2(COOLDOWN_FRAMES+1)`-bit counter loads `COOLDOWN_FRAMES` when the bullet retires.
  - It decrements on each `tick` while nonzero.
  - Launch requires the counter to be 0. A `tick` that decrements the counter never launches.
- Undefined:
  - Counter logic is absent and cooldown is treated as constant 0.
  - Launch is possible on the first `tick` after retirement.

## Structure
- Shared package `space_invaders_pkg` holds:
  - `bullet_state_t` enum {IDLE, FLYING}.
  - `SCREEN_W`=640, `SCREEN_H`=480.
  - Default `BULLET_STEP` and `BULLET_OFFSET_Y` constants.
- One sub-module, `frame_tick_sync`: synchronizer plus rising-edge detector producing `tick`.

## Test plan
- Reset held → all outputs 0; release `Reset` with no `fire` → `bullet_active` stays 0 through 5 frames.
- Launch and flight:
  - `playerX`=320, `playerY`=440, `fire` pulsed 1 cycle, then a frame → `bulletX`=320, `bulletY`=432, `bullet_active`=1, `shot_fired` high 1 cycle.
  - Next 3 frames → `bulletY` = 428, 424, 420.
  - `fire` held during flight → no relaunch, `bulletX` unchanged.
- Off-top exit: bullet at `bulletY`=3, then a frame → `bullet_active`=0, `bulletY` holds 3.
  - With `BULLET_COOLDOWN_EN` and `fire` held: no launch on the next 8 frames; launch on the 9th.
  - Without the macro: launch on the 1st frame.
- `hit` asserted in the same cycle as `tick` at `bulletY`=200 → `bullet_active`=0 after 1 edge, `bulletY` stays 200.
- `playerY`=4 launch → `bulletY`=0 (saturated), `bullet_active`=1; next frame → retires.
- `Reset` pulsed for less than one `Clk` period mid-flight → outputs 0 immediately; no `shot_fired` pulse afterward.
